// File: rtl/audio_codec_bridge.sv
// Audio CODEC <-> FIR sequencer: one L/R pair in flight, 4+FILT_LAT clocks per pair; output back-pressure stalls in WRITE.
// Optional `AUDIO_BRIDGE_STALL_CNT_EN adds a saturating stall_cnt of WRITE cycles with write_ready low.
module audio_codec_bridge #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned FILT_LAT = 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic [DATA_W-1:0] samp_left,
  output logic [DATA_W-1:0] samp_right,
  output logic              samp_valid,
  input  logic [DATA_W-1:0] filt_left,
  input  logic [DATA_W-1:0] filt_right,
  input  logic              write_ready,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              write
`ifdef AUDIO_BRIDGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_STROBE,
    S_WAIT,
    S_WRITE
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(FILT_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] samp_left_q, samp_left_d;
  logic [DATA_W-1:0] samp_right_q, samp_right_d;
  logic [DATA_W-1:0] wdata_left_q, wdata_left_d;
  logic [DATA_W-1:0] wdata_right_q, wdata_right_d;

  always_comb begin
    state_d       = state_q;
    lat_cnt_d     = lat_cnt_q;
    samp_left_d   = samp_left_q;
    samp_right_d  = samp_right_q;
    wdata_left_d  = wdata_left_q;
    wdata_right_d = wdata_right_q;
    read          = 1'b0;
    samp_valid    = 1'b0;
    write         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (read_ready) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Pops even if read_ready fell; that is a CODEC-side protocol error.
        read         = 1'b1;
        samp_left_d  = readdata_left;
        samp_right_d = readdata_right;
        state_d      = S_STROBE;
      end
      S_STROBE: begin
        samp_valid = 1'b1;
        lat_cnt_d  = LAT_INIT;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          wdata_left_d  = filt_left;
          wdata_right_d = filt_right;
          state_d       = S_WRITE;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      S_WRITE: begin
        write = write_ready;
        if (write_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lat_cnt_q     <= 4'd0;
      samp_left_q   <= '0;
      samp_right_q  <= '0;
      wdata_left_q  <= '0;
      wdata_right_q <= '0;
    end else begin
      state_q       <= state_d;
      lat_cnt_q     <= lat_cnt_d;
      samp_left_q   <= samp_left_d;
      samp_right_q  <= samp_right_d;
      wdata_left_q  <= wdata_left_d;
      wdata_right_q <= wdata_right_d;
    end
  end

  assign samp_left       = samp_left_q;
  assign samp_right      = samp_right_q;
  assign writedata_left  = wdata_left_q;
  assign writedata_right = wdata_right_q;

`ifdef AUDIO_BRIDGE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_WRITE) && !write_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_audio_codec_bridge.sv
// Bench for audio_codec_bridge: per-cycle vector table on a FILT_LAT=1 instance, hand sequences on a FILT_LAT=3 instance.
module tb_audio_codec_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- FILT_LAT = 1 instance, filter tied straight through
  logic        rst1, rr1, wr1, rd1, sv1, write1;
  logic [23:0] rdl1, rdr1, sl1, sr1, wdl1, wdr1;
`ifdef AUDIO_BRIDGE_STALL_CNT_EN
  logic [15:0] stall1, stall3;
`endif

  audio_codec_bridge #(.DATA_W(24), .FILT_LAT(1)) u_dut1 (
    .CLOCK_50        (clk),
    .reset           (rst1),
    .read_ready      (rr1),
    .readdata_left   (rdl1),
    .readdata_right  (rdr1),
    .read            (rd1),
    .samp_left       (sl1),
    .samp_right      (sr1),
    .samp_valid      (sv1),
    .filt_left       (sl1),
    .filt_right      (sr1),
    .write_ready     (wr1),
    .writedata_left  (wdl1),
    .writedata_right (wdr1),
    .write           (write1)
`ifdef AUDIO_BRIDGE_STALL_CNT_EN
    ,
    .stall_cnt       (stall1)
`endif
  );

  // ---------------- FILT_LAT = 3 instance, filter model inverts and is only valid on its slot
  logic        rst3, rr3, wr3, rd3, sv3, write3;
  logic [23:0] rdl3, rdr3, sl3, sr3, wdl3, wdr3, fl3, fr3;
  logic [2:0]  fv;
  logic [23:0] fpl [3];
  logic [23:0] fpr [3];

  always @(posedge clk) begin
    fv     <= {fv[1:0], sv3};
    fpl[0] <= ~sl3;
    fpr[0] <= ~sr3;
    fpl[1] <= fpl[0];
    fpr[1] <= fpr[0];
    fpl[2] <= fpl[1];
    fpr[2] <= fpr[1];
  end
  assign fl3 = fv[2] ? fpl[2] : 24'hBADBAD;
  assign fr3 = fv[2] ? fpr[2] : 24'hBADBAD;

  audio_codec_bridge #(.DATA_W(24), .FILT_LAT(3)) u_dut3 (
    .CLOCK_50        (clk),
    .reset           (rst3),
    .read_ready      (rr3),
    .readdata_left   (rdl3),
    .readdata_right  (rdr3),
    .read            (rd3),
    .samp_left       (sl3),
    .samp_right      (sr3),
    .samp_valid      (sv3),
    .filt_left       (fl3),
    .filt_right      (fr3),
    .write_ready     (wr3),
    .writedata_left  (wdl3),
    .writedata_right (wdr3),
    .write           (write3)
`ifdef AUDIO_BRIDGE_STALL_CNT_EN
    ,
    .stall_cnt       (stall3)
`endif
  );

  // ---------------- vector table for u_dut1: inputs during a cycle, outputs seen mid-cycle
  typedef struct {
    logic        rst, rr, wr;
    logic [23:0] rdl, rdr;
    logic        chk;
    logic        e_rd, e_sv, e_wr;
    logic [23:0] e_sl, e_sr, e_wl, e_wr_d;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rr, input logic wr,
                     input logic [23:0] rdl, input logic [23:0] rdr, input logic chk,
                     input logic e_rd, input logic e_sv, input logic e_wr,
                     input logic [23:0] e_sl, input logic [23:0] e_sr,
                     input logic [23:0] e_wl, input logic [23:0] e_wr_d);
    vec_t v;
    v.rst = rst; v.rr = rr; v.wr = wr; v.rdl = rdl; v.rdr = rdr; v.chk = chk;
    v.e_rd = e_rd; v.e_sv = e_sv; v.e_wr = e_wr;
    v.e_sl = e_sl; v.e_sr = e_sr; v.e_wl = e_wl; v.e_wr_d = e_wr_d;
    vecs.push_back(v);
  endtask

  logic [23:0] src_l [8];
  logic [23:0] src_r [8];
  int rd_cyc [8];
  int rd_n, wr_n, cyc, n_wr, rd_at, wr_at;
  bit saw_rd, found;

  localparam logic [23:0] A = 24'h4CA431, B = 24'hB835EB;
  localparam logic [23:0] C = 24'h0A0B0C, D = 24'hF0E0D0;
  localparam logic [23:0] E = 24'h123456, F = 24'hFEDCBA;
  localparam logic [23:0] Z = 24'h000000;

  initial begin
    // reset held 3 clocks with read_ready high
    add(1, 1, 1, A, B, 0,  0, 0, 0, Z, Z, Z, Z);
    add(1, 1, 1, A, B, 1,  0, 0, 0, Z, Z, Z, Z);
    add(1, 1, 1, A, B, 1,  0, 0, 0, Z, Z, Z, Z);
    // single pass, read_ready pulsed for one clock
    add(0, 1, 1, A, B, 1,  0, 0, 0, Z, Z, Z, Z);
    add(0, 0, 1, A, B, 1,  1, 0, 0, Z, Z, Z, Z);
    add(0, 0, 1, 24'h111111, 24'h222222, 1,  0, 1, 0, A, B, Z, Z);
    add(0, 0, 1, 24'h111111, 24'h222222, 1,  0, 0, 0, A, B, Z, Z);
    add(0, 0, 1, 24'h111111, 24'h222222, 1,  0, 0, 1, A, B, A, B);
    // second sample, then 10 clocks of back-pressure in WRITE
    add(0, 1, 1, C, D, 1,  0, 0, 0, A, B, A, B);
    add(0, 1, 1, C, D, 1,  1, 0, 0, A, B, A, B);
    add(0, 1, 1, C, D, 1,  0, 1, 0, C, D, A, B);
    add(0, 1, 0, C, D, 1,  0, 0, 0, C, D, A, B);
    for (int k = 0; k < 10; k++) add(0, 1, 0, C, D, 1,  0, 0, 0, C, D, C, D);
    add(0, 1, 1, C, D, 1,  0, 0, 1, C, D, C, D);
    // third sample follows normally after the stall releases
    add(0, 1, 1, E, F, 1,  0, 0, 0, C, D, C, D);
    add(0, 0, 1, E, F, 1,  1, 0, 0, C, D, C, D);
    add(0, 0, 1, E, F, 1,  0, 1, 0, E, F, C, D);
    add(0, 0, 1, E, F, 1,  0, 0, 0, E, F, C, D);
    add(0, 0, 1, E, F, 1,  0, 0, 1, E, F, E, F);
    add(0, 0, 1, E, F, 1,  0, 0, 0, E, F, E, F);

    for (int k = 0; k < 8; k++) begin
      src_l[k] = 24'hA50000 + 24'(k * 24'h011111);
      src_r[k] = 24'h5A00F0 - 24'(k * 24'h001357);
    end

    rst1 = 0; rr1 = 0; wr1 = 0; rdl1 = Z; rdr1 = Z;
    rst3 = 1; rr3 = 0; wr3 = 0; rdl3 = Z; rdr3 = Z;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      rst1 = vecs[i].rst; rr1 = vecs[i].rr; wr1 = vecs[i].wr;
      rdl1 = vecs[i].rdl; rdr1 = vecs[i].rdr;
      @(negedge clk);
      if (vecs[i].chk)
        check_eq($sformatf("vec%0d", i),
                 {29'd0, rd1, sv1, write1, sl1, sr1, wdl1, wdr1},
                 {29'd0, vecs[i].e_rd, vecs[i].e_sv, vecs[i].e_wr,
                  vecs[i].e_sl, vecs[i].e_sr, vecs[i].e_wl, vecs[i].e_wr_d});
      @(posedge clk); #1;
    end

    // streaming on the FILT_LAT=3 instance: 8 pairs, both ready sides held high
    rst3 = 0; rd_n = 0; wr_n = 0; cyc = 0;
    rdl3 = src_l[0]; rdr3 = src_r[0]; rr3 = 1; wr3 = 1;
    while (wr_n < 8 && cyc < 200) begin
      @(negedge clk);
      saw_rd = rd3;
      check_eq("rd_wr_overlap", {127'd0, rd3 & write3}, 128'd0);
      if (rd3 && rd_n < 8) begin
        if (rd_n > 0) check_eq($sformatf("rd_gap%0d", rd_n), cyc - rd_cyc[rd_n-1], 7);
        rd_cyc[rd_n] = cyc;
      end
      if (write3) begin
        check_eq($sformatf("wr_data%0d", wr_n), {wdl3, wdr3}, {~src_l[wr_n], ~src_r[wr_n]});
        check_eq($sformatf("rd_to_wr%0d", wr_n), cyc - rd_cyc[wr_n], 5);
        wr_n++;
      end
      @(posedge clk); #1;
      cyc++;
      if (saw_rd) begin
        rd_n++;
        if (rd_n < 8) begin
          rdl3 = src_l[rd_n]; rdr3 = src_r[rd_n];
        end else begin
          rr3 = 0;
        end
      end
    end
    check_eq("stream_timeout", {127'd0, cyc >= 200}, 128'd0);
    check_eq("stream_reads", rd_n, 8);
    check_eq("stream_writes", wr_n, 8);

    // reset asserted while the sample is waiting on the filter
    rdl3 = 24'h777777; rdr3 = 24'h888888; rr3 = 1; found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (sv3) begin found = 1; break; end
    end
    check_eq("mid_wait_strobe_seen", {127'd0, found}, 128'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst3 = 1;
    @(posedge clk); #1;
    rst3 = 0; rdl3 = 24'h3C3C3C; rdr3 = 24'hC3C3C3;
    @(negedge clk);
    check_eq("mid_wait_reset_outputs", {29'd0, rd3, sv3, write3, sl3, sr3, wdl3, wdr3}, 128'd0);
    n_wr = 0; rd_at = -1; wr_at = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rd_at >= 0) rr3 = 0;
      @(negedge clk);
      if (rd3 && rd_at < 0) rd_at = k;
      if (write3) begin
        n_wr++;
        if (wr_at < 0) begin
          wr_at = k;
          check_eq("mid_wait_next_data", {wdl3, wdr3}, {~24'h3C3C3C, ~24'hC3C3C3});
        end
      end
    end
    check_eq("mid_wait_next_read_at", rd_at, 1);
    check_eq("mid_wait_next_write_at", wr_at, 6);
    check_eq("mid_wait_write_count", n_wr, 1);

`ifdef AUDIO_BRIDGE_STALL_CNT_EN
    check_eq("stall_after_table", stall1, 16'd10);
    @(posedge clk); #1;
    rr1 = 1; wr1 = 0; rdl1 = A; rdr1 = B;
    @(posedge clk); #1;
    rr1 = 0;
    repeat (3) begin @(posedge clk); #1; end
    repeat (70000) @(posedge clk);
    #1;
    check_eq("stall_saturated", stall1, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    check_eq("stall_holds", stall1, 16'hFFFF);
    check_eq("stall_no_write", {127'd0, write1}, 128'd0);
    rst1 = 1;
    @(posedge clk); #1;
    rst1 = 0;
    check_eq("stall_reset", stall1, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
